// File: rtl/ad7124_pkg.sv
// ad7124_pkg
//   Shared constants for the AD7124 continuous-read SPI master: FSM state
//   codes, the read-data command byte and the status/CRC framing widths.
//   Optional feature macro used by the importing files: AD7124_CRC_EN.
package ad7124_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_RDY = 3'd1;
    localparam state_t ST_CMD      = 3'd2;
    localparam state_t ST_DATA     = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
    localparam state_t ST_GAP      = 3'd5;

    localparam logic [7:0] READ_DATA_CMD = 8'h42;
    localparam int         STATUS_BITS   = 8;
    localparam logic [7:0] CRC_POLY      = 8'h07;
    localparam int         CRC_BITS      = 8;

endpackage

// File: rtl/ad7124_crc8.sv
// ad7124_crc8
//   Bit-serial CRC-8 (polynomial x^8+x^2+x+1, init 0x00), MSB-first input.
//   Feeding a message followed by its own CRC leaves a zero residue.
//   The module only exists when AD7124_CRC_EN is defined.
// Ports
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   clear   in   synchronous clear of the CRC register
//   enable  in   shift bit_in into the CRC this cycle
//   bit_in  in   serial message bit
//   crc     out  current CRC register
`ifdef AD7124_CRC_EN
module ad7124_crc8
    import ad7124_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    input  logic                enable,
    input  logic                bit_in,
    output logic [CRC_BITS-1:0] crc
);

    logic feedback;
    assign feedback = crc[CRC_BITS-1] ^ bit_in;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_BITS-2:0], 1'b0} ^ (feedback ? CRC_POLY : 8'h00);
        end
    end

endmodule
`endif

// File: rtl/ad7124_stream_reader.sv
// ad7124_stream_reader
//   Continuous-read SPI master (mode 3) for the AD7124. Waits for DOUT/RDY
//   low, sends the read-data command, shifts in the data word plus status
//   byte and emits one sample with its channel number per conversion.
//   Optional feature: define AD7124_CRC_EN to clock 8 extra CRC bits and
//   reject frames whose CRC-8 residue is non-zero.
// Ports
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   en      in   run enable, sampled in IDLE only
//   sdo     in   ADC DOUT/RDY (already synchronised)
//   sclk    out  SPI clock, idles high
//   cs      out  chip select, active low
//   sdi     out  ADC DIN
//   dout    out  last good sample, held until the next valid
//   ch      out  channel of the last good sample
//   valid   out  one-cycle pulse when dout/ch are updated
//   err     out  one-cycle pulse on timeout, bad channel or CRC failure
//   busy    out  high whenever the FSM is not in IDLE
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | cs high, waiting for en
// WAIT_RDY | cs low, sclk high, waiting for two consecutive low sdo samples
// CMD      | clocking out the read-data command on sdi
// DATA     | clocking in data + status (+ CRC) from sdo
// DONE     | one cycle: raise cs, decode status, pulse valid or err
// GAP      | minimum cs-high time before returning to IDLE
module ad7124_stream_reader
    import ad7124_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int DATA_BITS = 24,
    parameter int NUM_CH    = 16,
    parameter int TIMEOUT   = 65536
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 sdo,
    output logic                 sclk,
    output logic                 cs,
    output logic                 sdi,
    output logic [DATA_BITS-1:0] dout,
    output logic [3:0]           ch,
    output logic                 valid,
    output logic                 err,
    output logic                 busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef AD7124_CRC_EN
    localparam int EXTRA_BITS = CRC_BITS;
`else
    localparam int EXTRA_BITS = 0;
`endif
    localparam int RX_BITS = DATA_BITS + STATUS_BITS + EXTRA_BITS;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [5:0]       RX_LAST  = 6'(RX_BITS - 1);
    localparam logic [5:0]       CMD_LAST = 6'd7;
    localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [5:0]         bit_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               low_seen;
    logic               gap_half;
    logic [RX_BITS-1:0] rx_sr;

    logic [3:0] rx_ch;
    logic       ch_ok;
    logic       crc_ok;

    // Received frame layout, MSB first: data, status, optional CRC.
    assign rx_ch = rx_sr[EXTRA_BITS +: 4];
    assign ch_ok = ({1'b0, rx_ch} < NUM_CH_L);
    assign busy  = (state != ST_IDLE);

`ifdef AD7124_CRC_EN
    logic                rise_now;
    logic                crc_bit;
    logic [CRC_BITS-1:0] crc_val;

    // The CRC sees exactly the bits on the wire: command bits as driven,
    // data/status/CRC bits as sampled, both at the sclk rising moment.
    assign rise_now = ((state == ST_CMD) || (state == ST_DATA)) && !sclk
                      && (div_cnt == DIV_LAST);
    assign crc_bit  = (state == ST_CMD) ? sdi : sdo;
    assign crc_ok   = (crc_val == '0);

    ad7124_crc8 u_crc (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state == ST_WAIT_RDY),
        .enable (rise_now),
        .bit_in (crc_bit),
        .crc    (crc_val)
    );
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cs       <= 1'b1;
            sclk     <= 1'b1;
            sdi      <= 1'b0;
            dout     <= '0;
            ch       <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            low_seen <= 1'b0;
            gap_half <= 1'b0;
            rx_sr    <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state    <= ST_WAIT_RDY;
                        cs       <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        tmo_cnt  <= '0;
                        low_seen <= 1'b0;
                    end
                end

                ST_WAIT_RDY: begin
                    low_seen <= ~sdo;
                    tmo_cnt  <= tmo_cnt + 1'b1;
                    // Ready wins over a timeout landing in the same cycle.
                    if (!sdo && low_seen) begin
                        state   <= ST_CMD;
                        sclk    <= 1'b0;
                        sdi     <= READ_DATA_CMD[7];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= ST_GAP;
                        err      <= 1'b1;
                        cs       <= 1'b1;
                        div_cnt  <= '0;
                        gap_half <= 1'b0;
                        tmo_cnt  <= '0;
                    end
                end

                ST_CMD: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_cnt == CMD_LAST) begin
                            state   <= ST_DATA;
                            sclk    <= 1'b0;
                            sdi     <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            sclk    <= 1'b0;
                            sdi     <= READ_DATA_CMD[3'(3'd6 - bit_cnt[2:0])];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[RX_BITS-2:0], sdo};
                            // Leave on the last rising edge so valid lands
                            // one clk after it.
                            if (bit_cnt == RX_LAST) begin
                                state   <= ST_DONE;
                                bit_cnt <= '0;
                            end
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    cs       <= 1'b1;
                    sclk     <= 1'b1;
                    state    <= ST_GAP;
                    div_cnt  <= '0;
                    gap_half <= 1'b0;
                    if (ch_ok && crc_ok) begin
                        dout  <= rx_sr[EXTRA_BITS + STATUS_BITS +: DATA_BITS];
                        ch    <= rx_ch;
                        valid <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end

                ST_GAP: begin
                    // Two passes of the divider give 2*CLK_DIV clks of cs high.
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (gap_half) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_half <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cs    <= 1'b1;
                    sclk  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad7124_stream_reader.sv
module tb_ad7124_stream_reader;

    localparam int CLK_DIV   = 4;
    localparam int DATA_BITS = 24;
    localparam int NUM_CH    = 4;
    localparam int TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic        sdo = 1'b1;
    logic        sclk, cs, sdi, valid, err, busy;
    logic [23:0] dout;
    logic [3:0]  ch;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_dout = '0;
    logic [3:0]  exp_ch = '0;

    always #5 clk = ~clk;

    ad7124_stream_reader #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .NUM_CH    (NUM_CH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .sdo    (sdo),
        .sclk   (sclk),
        .cs     (cs),
        .sdi    (sdi),
        .dout   (dout),
        .ch     (ch),
        .valid  (valid),
        .err    (err),
        .busy   (busy)
    );

`ifdef AD7124_CRC_EN
    // Remainder of msg * x^8 modulo x^8+x^2+x+1 by long division.
    function automatic logic [7:0] crc_of(input logic [39:0] msg);
        logic [47:0] r;
        r = {msg, 8'h00};
        for (int i = 47; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction
`endif

    // ADC model: drives RDY low after a delay, records DIN on sclk rises,
    // presents each frame bit after an sclk fall and garbles sdo while sclk
    // is high so a late sample would be caught.
    task automatic adc_serve(input logic [39:0] bits, input int nbits, input int rdy_delay,
                             output logic [7:0] cmd_seen, output int bad_half, output int sdi_bad);
        int budget;
        int rises;
        int edges;
        int hcnt;
        int idx;
        logic prev;
        cmd_seen = '0; bad_half = 0; sdi_bad = 0;
        rises = 0; edges = 0; hcnt = 0; idx = 0;
        sdo = 1'b1;
        budget = 0;
        while (cs !== 1'b0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        repeat (rdy_delay) @(negedge clk);
        sdo = 1'b0;
        prev = sclk;
        budget = 0;
        while (cs === 1'b0 && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (sclk !== prev) begin
                if (edges > 0 && hcnt != CLK_DIV) bad_half++;
                edges++;
                hcnt = 1;
                if (sclk === 1'b1) begin
                    rises++;
                    if (rises <= 8) cmd_seen = {cmd_seen[6:0], sdi};
                    else begin
                        if (sdi !== 1'b0) sdi_bad++;
                        sdo = ~sdo;
                    end
                end else if (rises >= 8 && idx < nbits) begin
                    sdo = bits[nbits-1-idx];
                    idx++;
                end
            end else begin
                hcnt++;
            end
            prev = sclk;
        end
        sdo = 1'b1;
    endtask

    task automatic run_frame(input logic [23:0] data, input logic [7:0] status, input int rdy_delay,
                             input bit corrupt, input string tag);
        logic [39:0] bits;
        int          nbits;
        logic        exp_ok;
        logic [7:0]  cmd_seen;
        int          bad_half, sdi_bad;
        int          nvalid, nerr, nboth, idle_bad;
        int          cyc, last_rise, valid_at, after;
        logic        seen_low, prev_sclk;
        exp_ok = (int'(status[3:0]) < NUM_CH);
`ifdef AD7124_CRC_EN
        bits  = {data, status, crc_of({8'h42, data, status})};
        nbits = 40;
        if (corrupt) begin
            bits[27] = ~bits[27];
            exp_ok = 1'b0;
        end
`else
        bits  = {8'h00, data, status};
        nbits = 32;
        if (corrupt) bits[39:32] = 8'h00;
`endif
        nvalid = 0; nerr = 0; nboth = 0; idle_bad = 0;
        cyc = 0; last_rise = -100; valid_at = -200; after = 0;
        seen_low = 1'b0; prev_sclk = 1'b1;
        en = 1'b1;
        fork
            adc_serve(bits, nbits, rdy_delay, cmd_seen, bad_half, sdi_bad);
            begin
                while (cyc < 3000 && after < 3) begin
                    @(negedge clk);
                    cyc++;
                    if (cs === 1'b0) begin
                        seen_low = 1'b1;
                        en = 1'b0;
                    end
                    if (cs === 1'b1 && sclk !== 1'b1) idle_bad++;
                    if (sclk === 1'b1 && prev_sclk === 1'b0) last_rise = cyc;
                    prev_sclk = sclk;
                    if (valid === 1'b1) begin nvalid++; valid_at = cyc; end
                    if (err === 1'b1) nerr++;
                    if (valid === 1'b1 && err === 1'b1) nboth++;
                    if (seen_low && cs === 1'b1) after++;
                end
            end
        join
        en = 1'b0;

        checks++;
        if (after < 3) begin errors++; $display("FAIL %s frame_timeout: frame did not finish in %0d clks", tag, cyc); end
        checks++;
        if (cmd_seen !== 8'h42) begin errors++; $display("FAIL %s cmd: got %h want 42", tag, cmd_seen); end
        checks++;
        if (bad_half !== 0) begin errors++; $display("FAIL %s sclk_half: %0d half-periods not %0d clks", tag, bad_half, CLK_DIV); end
        checks++;
        if (sdi_bad !== 0) begin errors++; $display("FAIL %s sdi_data: sdi high on %0d data bits, want 0", tag, sdi_bad); end
        checks++;
        if (idle_bad !== 0) begin errors++; $display("FAIL %s sclk_idle: sclk low on %0d cs-high clks, want 0", tag, idle_bad); end
        checks++;
        if (nboth !== 0) begin errors++; $display("FAIL %s valid_err_overlap: %0d cycles, want 0", tag, nboth); end
        if (exp_ok) begin
            exp_dout = data;
            exp_ch   = status[3:0];
            checks++;
            if (nvalid !== 1 || nerr !== 0) begin
                errors++; $display("FAIL %s pulses: valid %0d err %0d, want 1 and 0", tag, nvalid, nerr);
            end
            checks++;
            if (valid_at - last_rise !== 1) begin
                errors++; $display("FAIL %s latency: valid %0d clks after last sclk rise, want 1", tag, valid_at - last_rise);
            end
        end else begin
            checks++;
            if (nvalid !== 0 || nerr !== 1) begin
                errors++; $display("FAIL %s pulses: valid %0d err %0d, want 0 and 1", tag, nvalid, nerr);
            end
        end
        checks++;
        if (dout !== exp_dout) begin errors++; $display("FAIL %s dout: got %h want %h", tag, dout, exp_dout); end
        checks++;
        if (ch !== exp_ch) begin errors++; $display("FAIL %s ch: got %0d want %0d", tag, ch, exp_ch); end
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 0;
        while (busy !== 1'b0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s idle: busy still %b", tag, busy); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs, sclk, sdi, valid, err, busy} !== 6'b110000) begin
            errors++; $display("FAIL reset_ctl: cs/sclk/sdi/valid/err/busy = %b want 110000", {cs, sclk, sdi, valid, err, busy});
        end
        checks++;
        if (dout !== 24'h0 || ch !== 4'h0) begin
            errors++; $display("FAIL reset_data: dout %h ch %0d want 0 0", dout, ch);
        end
    endtask

    task automatic test_basic();
        run_frame(24'h123456, 8'h03, 3, 1'b0, "basic");
        wait_idle("basic");
    endtask

    task automatic test_bad_channel();
        run_frame(24'habcdef, 8'h05, 4, 1'b0, "bad_ch");
        wait_idle("bad_ch");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] st;
            st = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7))};
            run_frame(24'($urandom), st, $urandom_range(2, 12), 1'b0, "b2b");
        end
        wait_idle("b2b");
    endtask

    task automatic test_timeout();
        int cyc, t_low, t_err, cs_high, nerr2, nvalid;
        logic retried;
        sdo = 1'b1;
        en = 1'b1;
        cyc = 0; t_low = -1; t_err = -1; nvalid = 0;
        while (cyc < 500 && t_err < 0) begin
            @(negedge clk);
            cyc++;
            if (t_low < 0 && cs === 1'b0) t_low = cyc;
            if (err === 1'b1) t_err = cyc;
            if (valid === 1'b1) nvalid++;
        end
        checks++;
        if (t_err < 0 || t_err - t_low !== TIMEOUT) begin
            errors++; $display("FAIL timeout_delay: err at %0d clks after WAIT_RDY entry, want %0d", t_err - t_low, TIMEOUT);
        end
        cs_high = (cs === 1'b1) ? 1 : 0;
        retried = 1'b0;
        while (cyc < 1000 && !retried) begin
            @(negedge clk);
            cyc++;
            if (cs === 1'b1) cs_high++;
            else retried = 1'b1;
        end
        en = 1'b0;
        checks++;
        if (!retried || cs_high < 2 * CLK_DIV) begin
            errors++; $display("FAIL timeout_gap: retried %b cs high %0d clks, want retry after >= %0d", retried, cs_high, 2 * CLK_DIV);
        end
        nerr2 = 0;
        while (cyc < 1500 && busy !== 1'b0) begin
            @(negedge clk);
            cyc++;
            if (err === 1'b1) nerr2++;
            if (valid === 1'b1) nvalid++;
        end
        checks++;
        if (nerr2 !== 1 || nvalid !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_retry: second err %0d valid %0d busy %b, want 1 0 0", nerr2, nvalid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int budget, rises;
        logic prev;
        en = 1'b1;
        budget = 0;
        while (cs !== 1'b0 && budget < 100) begin @(negedge clk); budget++; end
        en = 1'b0;
        repeat (3) @(negedge clk);
        sdo = 1'b0;
        rises = 0; prev = sclk; budget = 0;
        while (rises < 14 && budget < 1000) begin
            @(negedge clk);
            budget++;
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
            sdo = $urandom_range(0, 1) != 0;
        end
        checks++;
        if (rises < 14) begin errors++; $display("FAIL rst_mid_reach: only %0d sclk rises, want 14", rises); end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({cs, sclk, valid, busy} !== 4'b1100) begin
            errors++; $display("FAIL rst_mid: cs/sclk/valid/busy = %b want 1100", {cs, sclk, valid, busy});
        end
        resetn = 1'b1;
        sdo = 1'b1;
        exp_dout = '0;
        exp_ch = '0;
        @(negedge clk);
        run_frame(24'h0badc0, 8'h81, 5, 1'b0, "after_rst");
        wait_idle("after_rst");
    endtask

`ifdef AD7124_CRC_EN
    task automatic test_crc();
        run_frame(24'h55aa33, 8'h02, 3, 1'b0, "crc_good");
        run_frame(24'h0f1e2d, 8'h01, 3, 1'b1, "crc_bad");
        wait_idle("crc");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_channel();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
`ifdef AD7124_CRC_EN
        test_crc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
